// File: rtl/led_rand_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_rand_pkg
// Description : Shared constants, state type and LFSR step helper for the
//               masked-LED fresh-randomness generator.
//               Lane slice layout (LANE_W bits per S-box):
//                 [R1_OFS +: R_W] = r1, [R2_OFS +: R_W] = r2,
//                 [R3_OFS +: R_W] = r3, [RS_OFS +: R_W] = rs
// Revision    : 1.0 - initial release
// ============================================================================
package led_rand_pkg;

    localparam int LANE_W = 24;
    localparam int R_W    = 6;

    localparam int R1_OFS = 0;
    localparam int R2_OFS = 6;
    localparam int R3_OFS = 12;
    localparam int RS_OFS = 18;

    // Feedback taps at bits 23, 22, 21 and 16.
    localparam logic [LANE_W-1:0] LFSR_TAPS = 24'hE1_0000;

    // Number of single-bit shifts that make up one lane advance.
    localparam int STEPS_PER_ADV = 24;

    // An all-zero LFSR state locks up, so a zero seed slice is replaced by this.
    localparam logic [LANE_W-1:0] SEED_FIX = 24'h00_0001;

    typedef enum logic [1:0] {
        NEED_SEED = 2'd0,
        WARMUP    = 2'd1,
        RUN       = 2'd2
    } state_e;

    // One Fibonacci LFSR shift: feedback enters at bit 0.
    function automatic logic [LANE_W-1:0] lfsr_step(input logic [LANE_W-1:0] s);
        return {s[LANE_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_rand_lane.sv
`default_nettype none
// ============================================================================
// Module      : led_rand_lane
// Description : One 24-bit LFSR randomness lane. Either loads a seed (with
//               zero-state fix) or performs a full 24-step advance per cycle.
// Ports       : clk, rst    - clock, asynchronous active-high reset
//               load_i      - load seed_i this cycle (takes priority)
//               seed_i      - seed slice for this lane
//               adv_i       - advance the lane by 24 LFSR steps
//               lane_o      - current lane state
// Revision    : 1.0 - initial release
// ============================================================================
module led_rand_lane
    import led_rand_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [LANE_W-1:0] seed_i,
    input  logic              adv_i,
    output logic [LANE_W-1:0] lane_o
);

    logic [LANE_W-1:0] lane_q;
    logic [LANE_W-1:0] lane_d;
    logic [LANE_W-1:0] adv_val;

    // Fully unrolled so every draw exposes 24 fresh bits.
    always_comb begin
        adv_val = lane_q;
        for (int k = 0; k < STEPS_PER_ADV; k++) begin
            adv_val = lfsr_step(adv_val);
        end
    end

    always_comb begin
        lane_d = lane_q;
        if (load_i) begin
            lane_d = (seed_i == '0) ? SEED_FIX : seed_i;
        end else if (adv_i) begin
            lane_d = adv_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q <= SEED_FIX;
        end else begin
            lane_q <= lane_d;
        end
    end

    assign lane_o = lane_q;

endmodule
`default_nettype wire

// File: rtl/led_rand_gen.sv
`default_nettype none
// ============================================================================
// Module      : led_rand_gen
// Description : Fresh-randomness source for masked LED pipelines. NUM_SBOX
//               independent LFSR lanes deliver 24 bits each per draw over a
//               valid/ready handshake, with seeding, warm-up and reseed limit.
// Ports       : clk, rst    - clock, asynchronous active-high reset
//               seed        - seed word, lane i = seed[24i+23:24i]
//               seed_valid  - seed offered; seed_ready - seed accepted
//               rnd         - randomness word (zero while not valid)
//               rnd_valid   - fresh unused draw present; rnd_ready - consume
//               reseed_req  - high while a seed is required
//               draw_cnt    - draws accepted since the last seed
// Macro       : LED_RAND_ZERO_EN - when defined, rnd is forced to zero while
//               handshake, lanes and counters run unchanged.
// Constraint  : RESEED_LIMIT < 2**CNT_W.
// Revision    : 1.0 - initial release
// ============================================================================
module led_rand_gen
    import led_rand_pkg::*;
#(
    parameter int unsigned NUM_SBOX     = 16,
    parameter int unsigned WARMUP_CYC   = 8,
    parameter int unsigned RESEED_LIMIT = 65535,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LANE_W*NUM_SBOX-1:0] seed,
    input  logic                       seed_valid,
    output logic                       seed_ready,
    output logic [LANE_W*NUM_SBOX-1:0] rnd,
    output logic                       rnd_valid,
    input  logic                       rnd_ready,
    output logic                       reseed_req,
    output logic [CNT_W-1:0]           draw_cnt
);

    localparam int unsigned       WC_W      = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC + 1) : 1;
    localparam logic [WC_W-1:0]   WC_LOAD   = WC_W'(WARMUP_CYC);
    localparam logic [WC_W-1:0]   WC_ONE    = WC_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(RESEED_LIMIT);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    state_e            state_q, state_d;
    logic [WC_W-1:0]   wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic                       lane_load;
    logic                       lane_adv;
    logic [LANE_W*NUM_SBOX-1:0] lanes;

    // ------------------------------------------------------------------
    // Next-state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        cnt_d      = cnt_q;
        lane_load  = 1'b0;
        lane_adv   = 1'b0;
        seed_ready = 1'b0;
        rnd_valid  = 1'b0;
        reseed_req = 1'b0;

        case (state_q)
            NEED_SEED: begin
                reseed_req = 1'b1;
                seed_ready = 1'b1;
                if (seed_valid) begin
                    lane_load = 1'b1;
                    cnt_d     = '0;
                    wcnt_d    = WC_LOAD;
                    state_d   = (WARMUP_CYC == 0) ? RUN : WARMUP;
                end
            end

            WARMUP: begin
                // Lanes free-run; the last advance coincides with entering RUN.
                lane_adv = 1'b1;
                if (wcnt_q <= WC_ONE) begin
                    state_d = RUN;
                end else begin
                    wcnt_d = wcnt_q - WC_ONE;
                end
            end

            RUN: begin
                rnd_valid  = 1'b1;
                seed_ready = 1'b1;
                if (seed_valid) begin
                    // A concurrent draw still consumes the value on rnd this
                    // cycle; the seed simply wins the lane update.
                    lane_load = 1'b1;
                    cnt_d     = '0;
                    wcnt_d    = WC_LOAD;
                    state_d   = (WARMUP_CYC == 0) ? RUN : WARMUP;
                end else if (rnd_ready) begin
                    lane_adv = 1'b1;
                    if (RESEED_LIMIT == 0) begin
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_d == CNT_LIMIT) begin
                            state_d = NEED_SEED;
                        end
                    end
                end
            end

            default: begin
                state_d = NEED_SEED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= NEED_SEED;
            wcnt_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign draw_cnt = cnt_q;

    // ------------------------------------------------------------------
    // Lanes
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_SBOX; i++) begin : g_lane
        led_rand_lane u_lane (
            .clk    (clk),
            .rst    (rst),
            .load_i (lane_load),
            .seed_i (seed[i*LANE_W +: LANE_W]),
            .adv_i  (lane_adv),
            .lane_o (lanes[i*LANE_W +: LANE_W])
        );
    end

    // Lanes only ever move on a load or an accepted draw, so rnd is stable
    // across a stall without a separate output register.
`ifdef LED_RAND_ZERO_EN
    assign rnd = '0;
`else
    assign rnd = rnd_valid ? lanes : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_led_rand_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_rand_gen
// Description : Self-checking bench for led_rand_gen. Two instances:
//               A: 1 lane, no warm-up, reseed after 3 draws.
//               B: 2 lanes, 8-cycle warm-up, unlimited draws, 4-bit counter.
//               A behavioural model tracks the expected presented values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_rand_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [23:0] a_seed;
    logic        a_seed_valid, a_seed_ready;
    logic [23:0] a_rnd;
    logic        a_rnd_valid, a_rnd_ready, a_reseed_req;
    logic [15:0] a_draw_cnt;

    logic [47:0] b_seed;
    logic        b_seed_valid, b_seed_ready;
    logic [47:0] b_rnd;
    logic        b_rnd_valid, b_rnd_ready, b_reseed_req;
    logic [3:0]  b_draw_cnt;

    led_rand_gen #(.NUM_SBOX(1), .WARMUP_CYC(0), .RESEED_LIMIT(3), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .seed(a_seed), .seed_valid(a_seed_valid),
        .seed_ready(a_seed_ready), .rnd(a_rnd), .rnd_valid(a_rnd_valid),
        .rnd_ready(a_rnd_ready), .reseed_req(a_reseed_req), .draw_cnt(a_draw_cnt)
    );

    led_rand_gen #(.NUM_SBOX(2), .WARMUP_CYC(8), .RESEED_LIMIT(0), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .seed(b_seed), .seed_valid(b_seed_valid),
        .seed_ready(b_seed_ready), .rnd(b_rnd), .rnd_valid(b_rnd_valid),
        .rnd_ready(b_rnd_ready), .reseed_req(b_reseed_req), .draw_cnt(b_draw_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int     W_CYC [2] = '{0, 8};
    int     LIMIT [2] = '{3, 0};
    longint CMAX  [2] = '{65535, 15};
    int     NL    [2] = '{1, 2};

    bit          m_need [2];
    int          m_wait [2];   // cycles remaining before a value is shown
    longint      m_cnt  [2];
    logic [23:0] m_lane [2][2];

    // n single-bit shifts of the 24-bit LFSR written arithmetically.
    function automatic logic [23:0] lfsr_adv(input logic [23:0] s0, input int n);
        int unsigned s = 32'(s0);
        for (int k = 0; k < n; k++) begin
            int unsigned fb = ((s >> 23) + (s >> 22) + (s >> 21) + (s >> 16)) % 2;
            s = ((s * 2) % 32'h100_0000) + fb;
        end
        return s[23:0];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_need[d] = 1'b1;
            m_wait[d] = 0;
            m_cnt[d]  = 0;
        end
    endtask

    task automatic model_update(input int d, input bit sv, input logic [47:0] sd, input bit rr);
        bit shown = !m_need[d] && (m_wait[d] == 0);
        bit sacc  = sv && (m_need[d] || m_wait[d] == 0);
        if (sacc) begin
            for (int i = 0; i < NL[d]; i++) begin
                logic [23:0] sl = sd[24*i +: 24];
                if (sl == 24'h0) sl = 24'h1;
                m_lane[d][i] = lfsr_adv(sl, 24 * W_CYC[d]);
            end
            m_need[d] = 1'b0;
            m_wait[d] = W_CYC[d];
            m_cnt[d]  = 0;
        end else if (shown && rr) begin
            for (int i = 0; i < NL[d]; i++) m_lane[d][i] = lfsr_adv(m_lane[d][i], 24);
            if (m_cnt[d] < CMAX[d]) m_cnt[d]++;
            if (LIMIT[d] != 0 && m_cnt[d] == LIMIT[d]) m_need[d] = 1'b1;
        end else if (m_wait[d] > 0) begin
            m_wait[d]--;
        end
    endtask

    task automatic check_dut(input int d);
        bit          shown = !m_need[d] && (m_wait[d] == 0);
        logic [47:0] exp_rnd = '0;
        if (shown) for (int i = 0; i < NL[d]; i++) exp_rnd[24*i +: 24] = m_lane[d][i];
        if (d == 0) begin
            check("a_rnd_valid",  64'(a_rnd_valid),  64'(shown));
            check("a_rnd",        64'(a_rnd),        64'(exp_rnd));
            check("a_reseed_req", 64'(a_reseed_req), 64'(m_need[0]));
            check("a_seed_ready", 64'(a_seed_ready), 64'(m_need[0] || m_wait[0] == 0));
            check("a_draw_cnt",   64'(a_draw_cnt),   64'(m_cnt[0]));
        end else begin
            check("b_rnd_valid",  64'(b_rnd_valid),  64'(shown));
            check("b_rnd",        64'(b_rnd),        64'(exp_rnd));
            check("b_reseed_req", 64'(b_reseed_req), 64'(m_need[1]));
            check("b_seed_ready", 64'(b_seed_ready), 64'(m_need[1] || m_wait[1] == 0));
            check("b_draw_cnt",   64'(b_draw_cnt),   64'(m_cnt[1]));
        end
    endtask

    // Called at a falling edge: check, drive, update model, wait one cycle.
    task automatic cycle(input bit a_sv, input logic [23:0] a_sd, input bit a_rr,
                         input bit b_sv, input logic [47:0] b_sd, input bit b_rr);
        check_dut(0);
        check_dut(1);
        a_seed_valid = a_sv; a_seed = a_sd; a_rnd_ready = a_rr;
        b_seed_valid = b_sv; b_seed = b_sd; b_rnd_ready = b_rr;
        model_update(0, a_sv, {24'h0, a_sd}, a_rr);
        model_update(1, b_sv, b_sd, b_rr);
        @(negedge clk);
    endtask

    function automatic logic [23:0] rnd_seed24();
        return ($urandom % 6 == 0) ? 24'h0 : 24'($urandom);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        a_seed = '0; a_seed_valid = 1'b0; a_rnd_ready = 1'b0;
        b_seed = '0; b_seed_valid = 1'b0; b_rnd_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state, then seed A with ABCDEF and B with a zero lane 0.
        cycle(1'b1, 24'hABCDEF, 1'b0, 1'b1, {24'h123456, 24'h000000}, 1'b0);
        for (int c = 0; c < 12; c++) cycle(1'b0, 24'h0, 1'b1, 1'b0, 48'h0, 1'b1);

        // Reseed A, then stall both for 5 cycles and resume.
        cycle(1'b1, 24'h5A5A5A, 1'b0, 1'b0, 48'h0, 1'b0);
        for (int c = 0; c < 5; c++) cycle(1'b0, 24'h0, 1'b0, 1'b0, 48'h0, 1'b0);
        for (int c = 0; c < 5; c++) cycle(1'b0, 24'h0, 1'b1, 1'b0, 48'h0, 1'b1);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            cycle(($urandom % 8) == 0, rnd_seed24(), ($urandom % 4) != 0,
                  ($urandom % 24) == 0, {rnd_seed24(), rnd_seed24()}, ($urandom % 4) != 0);
        end

        // B: long uninterrupted draw run to reach counter saturation.
        cycle(1'b0, 24'h0, 1'b1, 1'b1, {24'hC0FFEE, 24'h0BEEF0}, 1'b1);
        for (int c = 0; c < 40; c++) cycle(1'b0, 24'h0, 1'b1, 1'b0, 48'h0, 1'b1);

        // Simultaneous seed and draw on both instances.
        cycle(1'b1, 24'h13579B, 1'b1, 1'b1, {24'h2468AC, 24'hFEDCBA}, 1'b1);
        for (int c = 0; c < 3; c++) cycle(1'b0, 24'h0, 1'b1, 1'b0, 48'h0, 1'b1);

        // Reset while B is warming up: outputs return to reset values at once.
        #2 rst = 1'b1;
        #1 model_reset();
        check_dut(0);
        check_dut(1);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) cycle(1'b0, 24'h0, 1'b1, 1'b0, 48'h0, 1'b1);
        cycle(1'b1, 24'h000000, 1'b1, 1'b1, 48'h0, 1'b1);
        for (int c = 0; c < 12; c++) cycle(1'b0, 24'h0, 1'b1, 1'b0, 48'h0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_rand_gen.md
Name: led_rand_gen

Overview:
- Fresh-randomness source for the masked LED pipelines: the producer end of the r1/r2/r3/rs buses that the 3-share component functions consume.
- Holds NUM_SBOX independent 24-bit LFSR lanes; each lane supplies one S-box's 24 fresh bits per draw over a valid/ready handshake.
- Handles seeding, warm-up, a reseed limit, and stall-stable output, so cipher cores never see reused or partially updated masks.

Parameters:
- NUM_SBOX, 16, number of S-box lanes; output width is 24*NUM_SBOX.
- WARMUP_CYC, 8, free-running lane advances after each seed load before the first valid draw; 0 is legal.
- RESEED_LIMIT, 65535, accepted draws allowed per seed; 0 means unlimited.
- CNT_W, 16, draw-counter width; must satisfy RESEED_LIMIT < 2**CNT_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- seed  in  24*NUM_SBOX  seed word; lane i is seed[24i+23:24i]
- seed_valid  in  1  seed offered
- seed_ready  out  1  seed accepted when seed_valid & seed_ready
- rnd  out  24*NUM_SBOX  randomness; lane i slice: [5:0]=r1, [11:6]=r2, [17:12]=r3, [23:18]=rs
- rnd_valid  out  1  rnd holds a fresh, unused draw
- rnd_ready  in  1  consumer takes rnd when rnd_valid & rnd_ready
- reseed_req  out  1  high while a seed is required
- draw_cnt  out  CNT_W  draws accepted since the last seed

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-high.
- Reset values:
  - All lanes = 24'h000001; draw_cnt = 0.
  - State = NEED_SEED, so rnd_valid = 0, reseed_req = 1, seed_ready = 1.
  - rnd = all zero.
- Lane step (one LFSR shift):
  - fb = s[23]^s[22]^s[21]^s[16].
  - s_next = {s[22:0], fb}.
  - One "advance" = 24 unrolled steps in one cycle.
- Seed load: a lane whose seed slice is all zero is loaded as 24'h000001 (no lock-up).
- States:
  - NEED_SEED: rnd_valid = 0, reseed_req = 1. On seed handshake: load lanes, draw_cnt <= 0, then go to WARMUP, or to RUN if WARMUP_CYC = 0.
  - WARMUP: advance every cycle; a down-counter runs WARMUP_CYC cycles, then the state goes to RUN. seed_ready = 0 and rnd_valid = 0.
  - RUN:
    - rnd_valid = 1 and rnd = current lane state.
    - On a draw handshake: advance lanes and draw_cnt++.
    - If draw_cnt reaches RESEED_LIMIT (nonzero): go to NEED_SEED on the same edge; rnd_valid drops the next cycle.
    - seed_ready = 1.
- Stall: while rnd_valid & !rnd_ready, rnd and the lanes hold stable. Each lane value is presented exactly once.
- Seed in RUN: load lanes, draw_cnt <= 0, enter WARMUP (or stay in RUN with new lanes if WARMUP_CYC = 0); rnd_valid is low for at least WARMUP_CYC cycles.
- Seed and draw in the same cycle: the draw completes with the old rnd value, and the seed determines the next lane state. draw_cnt <= 0.
- Latency:
  - Seed handshake to first rnd_valid = WARMUP_CYC+1 cycles.
  - Back-to-back draws: one per cycle with no bubbles.
- draw_cnt saturates at 2**CNT_W-1 when RESEED_LIMIT = 0.
- Reset mid-operation: immediate return to the reset values; the seed must be supplied again.

Optional Feature:
- Macro: LED_RAND_ZERO_EN.
- Defined: rnd is forced to all zero. The handshake, state machine, lanes and counters run unchanged. Used for PROLEAD sanity runs, where leakage is required to be detected.
- Undefined: normal LFSR output.

Decomposition:
- Package led_rand_pkg holds:
  - LANE_W=24, R_W=6;
  - slice offsets R1_OFS=0, R2_OFS=6, R3_OFS=12, RS_OFS=18;
  - LFSR tap constants;
  - the state enum {NEED_SEED, WARMUP, RUN};
  - the seed-fix constant 24'h000001.
- Sub-module led_rand_lane: one 24-bit lane with the 24-step unrolled advance, load, and zero-fix. Instantiated NUM_SBOX times via generate.

Test Plan:
- Reset check: after reset -> rnd_valid=0, reseed_req=1, seed_ready=1, draw_cnt=0, rnd=0.
- First draw, WARMUP_CYC=0: NUM_SBOX=1, seed=24'hABCDEF -> rnd_valid high one cycle later with rnd=24'hABCDEF. Next draws match the reference-model 24-step advance; draw_cnt increments per handshake.
- Zero-seed fix and warm-up: WARMUP_CYC=8, seed with lane 0=0 -> rnd_valid stays low 8 cycles after the seed cycle. Lane 0 equals the model value for start 24'h000001 advanced 8 times.
- Stall then resume: hold rnd_ready=0 for 5 cycles in RUN -> rnd stable, draw_cnt unchanged. Resume -> no value skipped or repeated.
- Reseed limit: RESEED_LIMIT=3, three draws -> draw_cnt=3, rnd_valid=0 next cycle, reseed_req=1. Fourth seed restores RUN with draw_cnt=0.
- Simultaneous seed and draw in RUN: old rnd is consumed, new lanes are loaded, draw_cnt=0, WARMUP is entered. Also assert rst mid-WARMUP -> reset values immediately.
